// File: rtl/dcim_pkg.sv
// ============================================================================
//  Module   : dcim_pkg
//  Purpose  : Shared opcodes, FSM states and sizing helpers for the DCIM sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dcim_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_LOAD_W = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_LOAD_A  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam int unsigned NUM_PLANES    = 8;
    localparam int unsigned BYTES_PER_ACC = 2;

    // Width of a per-column popcount over `rows` rows.
    function automatic int unsigned ps_w(input int unsigned rows);
        return $clog2(rows + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcim_acc_lane.sv
// ============================================================================
//  Module   : dcim_acc_lane
//  Purpose  : One column shift-accumulator with sticky overflow.
//             DCIM_SIGNED_ACT_EN: plane 7 is subtracted, ovf tracks signed overflow.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dcim_acc_lane #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       plane,
    input  logic [PS_W-1:0]  psum,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [ACC_W-1:0] w_addend;
    logic [ACC_W-1:0] w_next;
    logic             w_ovf;

    always_comb begin
        w_addend = ACC_W'(psum) << plane;
`ifdef DCIM_SIGNED_ACT_EN
        if (plane == 3'd7) begin
            w_next = r_acc - w_addend;
            w_ovf  = (r_acc[ACC_W-1] != w_addend[ACC_W-1]) && (w_next[ACC_W-1] != r_acc[ACC_W-1]);
        end else begin
            w_next = r_acc + w_addend;
            w_ovf  = (r_acc[ACC_W-1] == w_addend[ACC_W-1]) && (w_next[ACC_W-1] != r_acc[ACC_W-1]);
        end
`else
        {w_ovf, w_next} = {1'b0, r_acc} + {1'b0, w_addend};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_acc <= w_next;
            if (w_ovf) r_ovf <= 1'b1;
        end
    end

    assign acc = r_acc;
    assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/dcim_seq_ctrl.sv
// ============================================================================
//  Module   : dcim_seq_ctrl
//  Purpose  : Host-command sequencer for the binary DCIM array (load, bit-serial
//             MAC, byte readback). Option macro: DCIM_SIGNED_ACT_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dcim_seq_ctrl
    import dcim_pkg::*;
#(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned ARR_LAT = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [3:0]                     cmd_len,
    input  logic                           din_valid,
    output logic                           din_ready,
    input  logic [7:0]                     din,
    output logic                           arr_we,
    output logic [$clog2(ROWS)-1:0]        arr_waddr,
    output logic [COLS-1:0]                arr_wdata,
    output logic                           arr_fire,
    output logic [ROWS-1:0]                arr_act,
    input  logic [COLS*ps_w(ROWS)-1:0]     arr_psum,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [7:0]                     res_data,
    output logic                           busy,
    output logic                           ovf
);

    localparam int unsigned c_ps_w   = ps_w(ROWS);
    localparam int unsigned c_cnt_w  = $clog2(ROWS + 1);
    localparam int unsigned c_aw     = $clog2(ROWS);
    localparam int unsigned c_lat_w  = $clog2(ARR_LAT + 1);
    localparam int unsigned c_nbytes = BYTES_PER_ACC * COLS;
    localparam int unsigned c_bw     = $clog2(c_nbytes);

    state_t               r_state, w_next_state;
    logic [c_cnt_w-1:0]   r_cnt, r_len, w_len_sat;
    logic [7:0]           r_act [ROWS];
    logic [2:0]           r_plane;
    logic [c_lat_w-1:0]   r_lat;
    logic [c_bw-1:0]      r_byte;
    logic [ACC_W-1:0]     w_acc [COLS];
    logic [COLS-1:0]      w_lane_ovf;
    logic                 w_cmd_fire, w_din_fire, w_last_row, w_sample, w_acc_clr;
    logic [15:0]          w_word;

    always_comb begin
        cmd_ready  = (r_state == ST_IDLE);
        busy       = (r_state != ST_IDLE);
        w_cmd_fire = cmd_valid && cmd_ready;
        w_acc_clr  = w_cmd_fire && (cmd_op == OP_RUN);
        din_ready  = ((r_state == ST_LOAD_W) && (r_cnt < r_len)) || (r_state == ST_LOAD_A);
        w_din_fire = din_valid && din_ready;
        w_last_row = (r_state == ST_LOAD_W) ? (r_cnt == r_len - 1'b1)
                                            : (r_cnt == c_cnt_w'(ROWS - 1));
        w_len_sat  = (32'(cmd_len) > ROWS) ? c_cnt_w'(ROWS) : c_cnt_w'(cmd_len);
        arr_we     = w_din_fire && (r_state == ST_LOAD_W);
        arr_waddr  = r_cnt[c_aw-1:0];
        arr_wdata  = COLS'(din);
        arr_fire   = (r_state == ST_COMPUTE) && (r_lat == '0);
        w_sample   = (r_state == ST_COMPUTE) && (r_lat == c_lat_w'(ARR_LAT));
        res_valid  = (r_state == ST_DRAIN);
        ovf        = |w_lane_ovf;
        for (int r = 0; r < ROWS; r++) arr_act[r] = arr_fire && r_act[r][r_plane];
        // Byte pairs per accumulator, low byte first; narrow accumulators zero-pad.
        w_word   = 16'(w_acc[r_byte[c_bw-1:1]]);
        res_data = res_valid ? (r_byte[0] ? w_word[15:8] : w_word[7:0]) : 8'h00;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    case (cmd_op)
                        OP_LOAD_W: w_next_state = ST_LOAD_W;
                        OP_RUN:    w_next_state = ST_LOAD_A;
                        OP_READ:   w_next_state = ST_DRAIN;
                        default:   w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD_W:  if ((r_len == '0) || (w_din_fire && w_last_row)) w_next_state = ST_IDLE;
            ST_LOAD_A:  if (w_din_fire && w_last_row) w_next_state = ST_COMPUTE;
            ST_COMPUTE: if (w_sample && (r_plane == 3'(NUM_PLANES - 1))) w_next_state = ST_IDLE;
            ST_DRAIN:   if (res_ready && (r_byte == c_bw'(c_nbytes - 1))) w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_len   <= '0;
            r_plane <= '0;
            r_lat   <= '0;
            r_byte  <= '0;
            for (int r = 0; r < ROWS; r++) r_act[r] <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_cnt   <= '0;
                r_len   <= w_len_sat;
                r_plane <= '0;
                r_lat   <= '0;
                r_byte  <= '0;
            end else if (w_din_fire) begin
                if (r_state == ST_LOAD_A) r_act[r_cnt[c_aw-1:0]] <= din;
                r_cnt <= w_last_row ? '0 : r_cnt + 1'b1;
            end
            // One plane at a time: fire, wait ARR_LAT cycles, sample, next plane.
            if (r_state == ST_COMPUTE) begin
                if (w_sample) begin
                    r_lat   <= '0;
                    r_plane <= r_plane + 3'd1;
                end else begin
                    r_lat <= r_lat + 1'b1;
                end
            end
            if (res_valid && res_ready) r_byte <= r_byte + 1'b1;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        dcim_acc_lane #(
            .ACC_W (ACC_W),
            .PS_W  (c_ps_w)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_acc_clr),
            .en    (w_sample),
            .plane (r_plane),
            .psum  (arr_psum[c*c_ps_w +: c_ps_w]),
            .acc   (w_acc[c]),
            .ovf   (w_lane_ovf[c])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_dcim_seq_ctrl.sv
// ============================================================================
//  Module   : tb_dcim_seq_ctrl
//  Purpose  : Directed bench for dcim_seq_ctrl with a behavioural 8x8 array.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcim_seq_ctrl;
    import dcim_pkg::*;

    localparam int ROWS = 8, COLS = 8, ACC_W = 16, ARR_LAT = 1, PS_W = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cmd_valid = 1'b0, cmd_ready;
    logic [1:0]             cmd_op = 2'b00;
    logic [3:0]             cmd_len = 4'd0;
    logic                   din_valid = 1'b0, din_ready;
    logic [7:0]             din = 8'h00;
    logic                   arr_we, arr_fire;
    logic [2:0]             arr_waddr;
    logic [COLS-1:0]        arr_wdata;
    logic [ROWS-1:0]        arr_act;
    logic [COLS*PS_W-1:0]   arr_psum = '0;
    logic                   res_valid, res_ready = 1'b0;
    logic [7:0]             res_data;
    logic                   busy, ovf;

    dcim_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .ARR_LAT(ARR_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .arr_we(arr_we), .arr_waddr(arr_waddr), .arr_wdata(arr_wdata),
        .arr_fire(arr_fire), .arr_act(arr_act), .arr_psum(arr_psum),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Behavioural array: weight memory and a one-cycle popcount.
    logic [7:0] wmem [ROWS];

    function automatic logic [PS_W-1:0] col_pop(input int c);
        logic [PS_W-1:0] s = '0;
        for (int r = 0; r < ROWS; r++) s += PS_W'(wmem[r][c] & arr_act[r]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (arr_we) wmem[arr_waddr] <= arr_wdata;
        if (arr_fire) for (int c = 0; c < COLS; c++) arr_psum[c*PS_W +: PS_W] <= col_pop(c);
    end

    int n_pass = 0, n_total = 0;
    logic [7:0] rx [16];
    int cyc, fires;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (k == 200) check("idle_timeout", 0, 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] len);
        wait_idle();
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        din_valid = 1'b1; din = b;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (din_ready) break;
        end
        if (k == 50) check("din_timeout", 0, 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic recv_byte(input int idx);
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        if (k == 50) check("res_timeout", 0, 1);
        rx[idx] = res_data;
        @(posedge clk); #1;
    endtask

    task automatic read_all();
        issue(OP_READ, 4'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) recv_byte(i);
        res_ready = 1'b0;
    endtask

    // Feeds 8 activation bytes then counts busy cycles and fire pulses of COMPUTE.
    task automatic run_uniform(input logic [7:0] a);
        issue(OP_RUN, 4'd0);
        for (int r = 0; r < ROWS; r++) send_byte(a);
        cyc = 0; fires = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (arr_fire) fires++;
        end
    endtask

    typedef struct {
        logic [7:0]  w;
        logic [7:0]  a;
        logic [15:0] exp_u;
        logic [15:0] exp_s;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [15:0] exp_col, got_col;
        logic [7:0]  held, orv;
        int          n, bad, stable;

        vecs[0] = '{w: 8'hFF, a: 8'h01, exp_u: 16'h0008, exp_s: 16'h0008};
        vecs[1] = '{w: 8'hFF, a: 8'hFF, exp_u: 16'h07F8, exp_s: 16'hFFF8};
        vecs[2] = '{w: 8'h0F, a: 8'h80, exp_u: 16'h0400, exp_s: 16'hFC00};
        vecs[3] = '{w: 8'hAA, a: 8'h3C, exp_u: 16'h01E0, exp_s: 16'h01E0};
        vecs[4] = '{w: 8'h00, a: 8'hFF, exp_u: 16'h0000, exp_s: 16'h0000};

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_arr_we", arr_we, 0);
        check("rst_arr_fire", arr_fire, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_din_ready", din_ready, 0);

        read_all();
        orv = 8'h00;
        for (int i = 0; i < 16; i++) orv |= rx[i];
        check("read_before_run", orv, 0);

        // din in IDLE must be ignored
        din_valid = 1'b1; din = 8'hA5; n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (arr_we || din_ready) n++;
        end
        din_valid = 1'b0;
        check("din_ignored_idle", n, 0);

        for (int v = 0; v < 5; v++) begin
            issue(OP_LOAD_W, 4'd8);
            for (int r = 0; r < ROWS; r++) send_byte(vecs[v].w);
            run_uniform(vecs[v].a);
            check($sformatf("v%0d_compute_cycles", v), cyc, 16);
            check($sformatf("v%0d_fires", v), fires, 8);
            check($sformatf("v%0d_ovf", v), ovf, 0);
            read_all();
            for (int c = 0; c < COLS; c++) begin
`ifdef DCIM_SIGNED_ACT_EN
                exp_col = vecs[v].w[c] ? vecs[v].exp_s : 16'h0000;
`else
                exp_col = vecs[v].w[c] ? vecs[v].exp_u : 16'h0000;
`endif
                got_col = {rx[2*c+1], rx[2*c]};
                check($sformatf("v%0d_col%0d", v, c), got_col, exp_col);
            end
        end

        // LOAD_W with zero length: back to IDLE next cycle, no writes
        issue(OP_LOAD_W, 4'd0);
        din_valid = 1'b1; din = 8'h55; n = 0;
        @(negedge clk); if (arr_we) n++;
        @(negedge clk); if (arr_we) n++;
        check("len0_idle_next", busy, 0);
        @(negedge clk); if (arr_we) n++;
        din_valid = 1'b0;
        check("len0_no_writes", n, 0);

        // LOAD_W with length 12 saturates at 8 rows
        issue(OP_LOAD_W, 4'd12);
        din_valid = 1'b1; din = 8'h3C; n = 0; bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (arr_we) begin
                if (arr_waddr != 3'(n)) bad++;
                n++;
            end
        end
        din_valid = 1'b0;
        check("len12_writes", n, 8);
        check("len12_addr_order", bad, 0);
        check("len12_idle", cmd_ready, 1);

        // Reset during COMPUTE plane 3
        issue(OP_LOAD_W, 4'd8);
        for (int r = 0; r < ROWS; r++) send_byte(8'hFF);
        issue(OP_RUN, 4'd0);
        for (int r = 0; r < ROWS; r++) send_byte(8'hFF);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (arr_fire) n++;
            if (n == 4) break;
        end
        check("rst_mid_reached_plane3", n, 4);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst_mid_idle", {busy, cmd_ready}, 2'b01);
        read_all();
        orv = 8'h00;
        for (int i = 0; i < 16; i++) orv |= rx[i];
        check("rst_mid_read_zero", orv, 0);

        // Unique per-column results with a 5-cycle res_ready stall
        issue(OP_LOAD_W, 4'd8);
        for (int r = 0; r < ROWS; r++) send_byte(8'(1 << r));
        issue(OP_RUN, 4'd0);
        for (int r = 0; r < ROWS; r++) send_byte(8'(r * 17 + 1));
        issue(OP_READ, 4'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) recv_byte(i);
        res_ready = 1'b0;
        @(negedge clk);
        held = res_data; stable = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res_data != held || !res_valid) stable = 0;
        end
        check("stall_stable", stable, 1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        for (int i = 5; i < 16; i++) recv_byte(i);
        res_ready = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            check($sformatf("stall_col%0d_lo", c), rx[2*c], 8'(c * 17 + 1));
            check($sformatf("stall_col%0d_hi", c), rx[2*c+1], 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
